booth4_macc_seq: RTL

Sequential, parametrised radix-4 Booth multiply-accumulate unit for the CNN ALU MACC path. It retires one Booth digit per clock, so a W×W signed multiply takes W/2 cycles. It produces the full 2W-bit signed product with no dropped MSB. An ACC_W-bit accumulator supports clear-or-accumulate per operation, with optional saturation and a sticky overflow flag. Valid/ready handshakes on both sides let it sit between the operand feeder and the partial-sum writeback.

---
 rtl/booth_pkg.sv | 28 ++
 rtl/radix4_digit_enc.sv | 25 ++
 rtl/booth4_macc_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth MACC unit.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } digit_ctl_t;

    localparam int unsigned DEF_W = 8;
    localparam int unsigned NDIG  = DEF_W / 2;
    localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    function automatic int unsigned ndig(input int unsigned w);
        return w / 2;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned w);
        return ((w / 2) > 1) ? $clog2(w / 2) : 1;
    endfunction

endpackage

// File: rtl/radix4_digit_enc.sv
// Radix-4 Booth recoder: {y[2k+1], y[2k], y[2k-1]} -> sign / x1 / x2 select.
module radix4_digit_enc
    import booth_pkg::*;
(
    input  logic [2:0] bits,
    output digit_ctl_t ctl
);

    // Map each bit triple to the digit in {-2,-1,0,+1,+2}.
    always_comb begin
        ctl = '{neg: 1'b0, one: 1'b0, two: 1'b0};
        case (bits)
            3'b000:  ctl = '{neg: 1'b0, one: 1'b0, two: 1'b0};
            3'b001:  ctl = '{neg: 1'b0, one: 1'b1, two: 1'b0};
            3'b010:  ctl = '{neg: 1'b0, one: 1'b1, two: 1'b0};
            3'b011:  ctl = '{neg: 1'b0, one: 1'b0, two: 1'b1};
            3'b100:  ctl = '{neg: 1'b1, one: 1'b0, two: 1'b1};
            3'b101:  ctl = '{neg: 1'b1, one: 1'b1, two: 1'b0};
            3'b110:  ctl = '{neg: 1'b1, one: 1'b1, two: 1'b0};
            3'b111:  ctl = '{neg: 1'b0, one: 1'b0, two: 1'b0};
            default: ctl = '{neg: 1'b0, one: 1'b0, two: 1'b0};
        endcase
    end

endmodule

// File: rtl/booth4_macc_seq.sv
// Sequential radix-4 Booth multiply-accumulate: one digit per clock, full
// 2W-bit product, clear-or-accumulate with optional saturation and sticky overflow.
module booth4_macc_seq
    import booth_pkg::*;
#(
    parameter int W     = 8,
    parameter int ACC_W = 32,
    parameter int SAT   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       x,
    input  logic [W-1:0]       y,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     o_mul,
    output logic [ACC_W-1:0]   o_acc,
    output logic               ovf
);

    localparam int ND = ndig(W);
    localparam int CW = cnt_w(W);
    localparam int P  = 2 * W;

    state_e             state_r;
    state_e             state_s;
    logic [W-1:0]       x_r;
    logic [W-1:0]       y_r;
    logic               clr_r;
    logic [CW-1:0]      k_r;
    logic [P-1:0]       pp_r;

    logic               last_s;
    logic [W:0]         y_ext_s;
    logic [W:0]         y_sh_s;
    digit_ctl_t         ctl_s;
    logic [P-1:0]       xs_s;
    logic [P-1:0]       mag_s;
    logic [P-1:0]       sh_s;
    logic [P-1:0]       addend_s;
    logic [P-1:0]       pp_nx_s;
    logic [ACC_W-1:0]   prod_ext_s;
    logic [ACC_W-1:0]   sum_s;
    logic [ACC_W-1:0]   sat_s;
    logic               sum_ovf_s;
    logic [ACC_W-1:0]   acc_nx_s;
    logic               ovf_nx_s;

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign last_s    = (k_r == CW'(ND - 1));

    // Current digit triple, with an implicit zero below y[0].
    assign y_ext_s = {y_r, 1'b0};
    assign y_sh_s  = y_ext_s >> {k_r, 1'b0};

    radix4_digit_enc u_enc (
        .bits (y_sh_s[2:0]),
        .ctl  (ctl_s)
    );

    // Partial-product step: +/-(1|2)*x at weight 4^k; negation is invert plus carry-in.
    always_comb begin
        xs_s     = {{W{x_r[W-1]}}, x_r};
        mag_s    = {P{1'b0}};
        if (ctl_s.one) begin
            mag_s = xs_s;
        end else if (ctl_s.two) begin
            mag_s = xs_s << 1;
        end else begin
            mag_s = {P{1'b0}};
        end
        sh_s     = mag_s << {k_r, 1'b0};
        addend_s = ctl_s.neg ? ~sh_s : sh_s;
        pp_nx_s  = pp_r + addend_s + {{(P-1){1'b0}}, ctl_s.neg};
    end

    // Accumulator update with signed-overflow detection and optional clamp.
    always_comb begin
        prod_ext_s = ACC_W'($signed(pp_nx_s));
        sum_s      = o_acc + prod_ext_s;
        sum_ovf_s  = (o_acc[ACC_W-1] == prod_ext_s[ACC_W-1]) &&
                     (sum_s[ACC_W-1] != o_acc[ACC_W-1]);
        sat_s      = o_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
        acc_nx_s   = o_acc;
        ovf_nx_s   = ovf;
        if (clr_r) begin
            acc_nx_s = prod_ext_s;
            ovf_nx_s = 1'b0;
        end else if (sum_ovf_s) begin
            acc_nx_s = (SAT != 0) ? sat_s : sum_s;
            ovf_nx_s = 1'b1;
        end else begin
            acc_nx_s = sum_s;
            ovf_nx_s = ovf;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Operand capture, digit iteration and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_r   <= {W{1'b0}};
            y_r   <= {W{1'b0}};
            clr_r <= 1'b0;
            k_r   <= {CW{1'b0}};
            pp_r  <= {P{1'b0}};
            o_mul <= {P{1'b0}};
            o_acc <= {ACC_W{1'b0}};
            ovf   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        x_r   <= x;
                        y_r   <= y;
                        clr_r <= acc_clr;
                        k_r   <= {CW{1'b0}};
                        pp_r  <= {P{1'b0}};
                    end
                end
                CALC: begin
                    pp_r <= pp_nx_s;
                    k_r  <= k_r + CW'(1);
                    if (last_s) begin
                        o_mul <= pp_nx_s;
                        o_acc <= acc_nx_s;
                        ovf   <= ovf_nx_s;
                    end
                end
                default: begin
                    pp_r <= pp_r;
                end
            endcase
        end
    end

endmodule
